bcd_seg_scanner: RTL and testbench

Time-multiplexed driver for a 3-digit common-anode seven-segment display. Consumes the 12-bit packed BCD value produced by the BCD incrementor/counter stage and latches it into a shadow register on a load strobe. Scans the three digits with a programmable dwell time and an inter-digit blanking gap that suppresses ghosting. Flags non-BCD nibbles. Sits directly downstream of the BCD arithmetic path and drives FPGA pins.

---
 rtl/bcd_seg_scanner.sv | 134 +++++++++++++
 tb/tb_bcd_seg_scanner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bcd_seg_scanner.sv
// Three-digit common-anode seven-segment scanner with a shadowed BCD value.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.

module bcd_seg_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg,
  output logic       bad
);
  // Active-low, bit order {g,f,e,d,c,b,a}; non-BCD nibbles show a dash.
  always_comb begin
    seg = 7'b0111111;
    case (nib)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    bad = (nib > 4'd9);
  end
endmodule

module bcd_seg_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] value,
  input  logic        load,
  output logic [6:0]  segments,
  output logic [2:0]  anodes,
  output logic        invalid
);
  localparam int NUM_DIGITS = 3;
  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] REF_TC = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK_TC = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                         state, state_nxt;
  logic [1:0]                     idx, idx_nxt;
  logic [CW-1:0]                  cnt, cnt_nxt;
  logic [11:0]                    shadow;
  logic [NUM_DIGITS-1:0][6:0]     dec;
  logic [NUM_DIGITS-1:0]          bad;
  logic [2:0]                     an_nxt;
  logic [6:0]                     seg_nxt;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_seg_dec u_dec (
        .nib (shadow[4*g +: 4]),
        .seg (dec[g]),
        .bad (bad[g])
      );
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BLANK;
      idx   <= 2'd2;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 1'b1;
    an_nxt    = 3'b111;
    seg_nxt   = 7'b1111111;
    case (state)
      BLANK: begin
        if (cnt == BLK_TC) begin
          state_nxt = SHOW;
          idx_nxt   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        an_nxt  = ~(3'b001 << idx);
        seg_nxt = dec[idx];
`ifdef BCD_SCAN_LZB_EN
        // Only true zeros are suppressed; a dash in a leading slot stays visible.
        if ((idx == 2'd2 && shadow[11:8] == 4'd0) ||
            (idx == 2'd1 && shadow[11:4] == 8'd0)) begin
          an_nxt  = 3'b111;
          seg_nxt = 7'b1111111;
        end
`else
`endif
        if (cnt == REF_TC) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the registered state and shadow, so a Load shows
  // one edge after capture and anodes/segments always switch together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow   <= 12'h000;
      anodes   <= 3'b111;
      segments <= 7'b1111111;
      invalid  <= 1'b0;
    end else begin
      if (load) shadow <= value;
      anodes   <= an_nxt;
      segments <= seg_nxt;
      invalid  <= |bad;
    end
  end
endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed scoreboard bench for bcd_seg_scanner with REFRESH_DIV=4, BLANK_CYCLES=2.
// Expectations are queued per edge and compared one unit after each rising edge.

module tb_bcd_seg_scanner;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] value;
  logic        load;
  logic [6:0]  segments;
  logic [2:0]  anodes;
  logic        invalid;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  localparam logic [2:0] OFF = 3'b111, U = 3'b110, T = 3'b101, H = 3'b011;
  localparam logic [6:0] BL  = 7'b1111111;

  bcd_seg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clock    (clk),
    .reset    (rst),
    .value    (value),
    .load     (load),
    .segments (segments),
    .anodes   (anodes),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [10:0] exp, input string tag);
    logic [10:0] got;
    got = {anodes, segments, invalid};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: an/seg/inv got %b/%b/%b exp %b/%b/%b", tag,
             got[10:8], got[7:1], got[0], exp[10:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic push(input logic [2:0] an, input logic [6:0] seg, input logic inv,
                      input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({an, seg, inv});
      tag_q.push_back(tag);
    end
  endtask

  // Pops n entries (0 = everything queued), one per rising edge.
  task automatic drain(input int n);
    int k;
    k = (n == 0) ? exp_q.size() : n;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      check(exp_q.pop_front(), tag_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = 12'h000;
    #12;
    check({OFF, BL, 1'b0}, "reset_state");

    // Scan of 0x123 through one full frame plus the next units slot.
    @(negedge clk);
    rst = 1'b0; load = 1'b1; value = 12'h123;
    push(OFF, BL, 0, 2, "f123_blank0");
    push(U, 7'b0110000, 0, 4, "f123_units");
    push(OFF, BL, 0, 2, "f123_blank1");
    push(T, 7'b0100100, 0, 4, "f123_tens");
    push(OFF, BL, 0, 2, "f123_blank2");
    push(H, 7'b1111001, 0, 4, "f123_hund");
    push(OFF, BL, 0, 2, "f123_blank3");
    push(U, 7'b0110000, 0, 4, "f123_units_rep");
    drain(1);
    load = 1'b0; value = 12'h456;
    drain(0);

    // Invalid nibble: 0x9A5, then recovery with 0x905.
    load = 1'b1; value = 12'h9A5;
    push(OFF, BL, 0, 1, "bad_ld_edge");
    push(OFF, BL, 1, 1, "bad_inv_rise");
    push(T, 7'b0111111, 1, 4, "bad_tens_dash");
    push(OFF, BL, 1, 2, "bad_blank");
    push(H, 7'b0010000, 1, 4, "bad_hund9");
    push(OFF, BL, 1, 2, "bad_blank2");
    push(U, 7'b0010010, 1, 4, "bad_units5");
    drain(1);
    load = 1'b0;
    drain(0);
    load = 1'b1; value = 12'h905;
    push(OFF, BL, 1, 1, "fix_ld_edge");
    push(OFF, BL, 0, 1, "fix_inv_fall");
    push(T, 7'b1000000, 0, 4, "fix_tens0");
    drain(1);
    load = 1'b0;
    drain(0);

    // Value moves without Load; then a one-cycle Load mid units slot.
    value = 12'h321;
    push(OFF, BL, 0, 2, "mid_blank");
    push(H, 7'b0010000, 0, 4, "mid_hund_noload");
    push(OFF, BL, 0, 2, "mid_blank2");
    push(U, 7'b0010010, 0, 2, "mid_units_old");
    drain(0);
    load = 1'b1; value = 12'h777;
    push(U, 7'b0010010, 0, 1, "mid_units_ldedge");
    drain(1);
    load = 1'b0; value = 12'h111;
    push(U, 7'b1111000, 0, 1, "mid_units_new");
    push(OFF, BL, 0, 2, "mid_dwell_end");
    push(T, 7'b1111000, 0, 4, "mid_tens7");
    push(OFF, BL, 0, 2, "mid_blank3");
    push(H, 7'b1111000, 0, 4, "mid_hund7");
    push(OFF, BL, 0, 2, "mid_blank4");
    push(U, 7'b1111000, 0, 2, "pre_rst_units");
    drain(0);

    // Asynchronous reset in the middle of a lit units slot.
    #2 rst = 1'b1;
    #1 check({OFF, BL, 1'b0}, "async_rst");
    @(negedge clk);
    rst = 1'b0;
    push(OFF, BL, 0, 2, "post_rst_blank");
    push(U, 7'b1000000, 0, 4, "post_rst_units0");
    drain(0);

    // Leading zeros with 0x007.
    load = 1'b1; value = 12'h007;
    push(OFF, BL, 0, 1, "lz_ld_edge");
    drain(1);
    load = 1'b0;
    push(OFF, BL, 0, 1, "lz_blank");
`ifdef BCD_SCAN_LZB_EN
    push(OFF, BL, 0, 4, "lz_tens_off");
    push(OFF, BL, 0, 2, "lz_blank2");
    push(OFF, BL, 0, 4, "lz_hund_off");
`else
    push(T, 7'b1000000, 0, 4, "lz_tens0");
    push(OFF, BL, 0, 2, "lz_blank2");
    push(H, 7'b1000000, 0, 4, "lz_hund0");
`endif
    push(OFF, BL, 0, 2, "lz_blank3");
    push(U, 7'b1111000, 0, 4, "lz_units7");
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
